// File: rtl/fp_div_pkg.sv
// Shared types and constants for the single-precision divider.
package fp_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned BIAS   = 127;
    localparam int unsigned ITER   = 26;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned EXP_W  = 10;
    localparam int unsigned MANT_W = 24;
    localparam int unsigned REM_W  = 25;
    localparam int unsigned Q_W    = 26;
    localparam int unsigned CNT_W  = 5;

    localparam logic [WORD_W-1:0] QNAN    = 32'h7FC00000;
    localparam logic [WORD_W-1:0] POS_INF = 32'h7F800000;

    // Normalized, not-yet-rounded quotient handed to the rounder.
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
        logic              guard;
        logic              sticky;
    } norm_t;

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even, renormalize on carry, range-check and pack.
module fp_round_pack
    import fp_div_pkg::*;
(
    input  logic                    sign,
    input  logic signed [EXP_W-1:0] exp,
    input  logic [MANT_W-1:0]       mantissa,
    input  logic                    guard,
    input  logic                    sticky,
    output logic [WORD_W-1:0]       result_c,
    output logic                    overflow_c,
    output logic                    underflow_c
);

    logic                    round_up;
    logic [MANT_W:0]         mant_sum;
    logic [MANT_W-1:0]       mant_fin;
    logic signed [EXP_W-1:0] exp_fin;
    logic                    unused_hidden_bit;

    // Rounding, carry renormalization and overflow/underflow clamping.
    always_comb begin
        round_up    = guard & (sticky | mantissa[0]);
        mant_sum    = {1'b0, mantissa} + (MANT_W+1)'(round_up);
        mant_fin    = mant_sum[MANT_W-1:0];
        exp_fin     = exp;
        overflow_c  = 1'b0;
        underflow_c = 1'b0;
        if (mant_sum[MANT_W]) begin
            mant_fin = mant_sum[MANT_W:1];
            exp_fin  = exp + 10'sd1;
        end
        result_c = {sign, exp_fin[7:0], mant_fin[MANT_W-2:0]};
        if (exp_fin >= 10'sd255) begin
            result_c   = {sign, POS_INF[WORD_W-2:0]};
            overflow_c = 1'b1;
        end else if (exp_fin <= 10'sd0) begin
            result_c    = {sign, 31'd0};
            underflow_c = 1'b1;
        end
    end

    // The hidden bit is implicit in the packed word.
    assign unused_hidden_bit = mant_fin[MANT_W-1];

endmodule

// File: rtl/floating_point_divider.sv
// Fixed-latency IEEE-754 single-precision divider (restoring, 1 bit/cycle).
module floating_point_divider
    import fp_div_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    output logic [WORD_W-1:0] Quotient,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic              overflow,
    output logic              underflow
);

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt;
    logic [REM_W-1:0]    rem;
    logic [Q_W-1:0]      q;
    logic [MANT_W-1:0]   mant_b;
    logic                sign_r;
    logic [EXP_W-1:0]    exp_r;
    logic                spec_r;
    logic                spec_dbz_r;
    logic [WORD_W-1:0]   spec_val_r;
    norm_t               norm_r;

    logic                spec_c;
    logic                spec_dbz_c;
    logic [WORD_W-1:0]   spec_val_c;
    logic                ge_c;
    logic [REM_W-1:0]    rem_step_c;
    logic [REM_W-1:0]    rem_next_c;
    norm_t               norm_c;
    logic [WORD_W-1:0]   rp_result_c;
    logic                rp_overflow_c;
    logic                rp_underflow_c;

    // Special-operand classification, in priority order.
    always_comb begin
        logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, s;
        a_zero     = (A[30:23] == 8'd0);
        b_zero     = (B[30:23] == 8'd0);
        a_inf      = (A[30:23] == 8'hFF) && (A[22:0] == 23'd0);
        b_inf      = (B[30:23] == 8'hFF) && (B[22:0] == 23'd0);
        a_nan      = (A[30:23] == 8'hFF) && (A[22:0] != 23'd0);
        b_nan      = (B[30:23] == 8'hFF) && (B[22:0] != 23'd0);
        s          = A[31] ^ B[31];
        spec_c     = 1'b1;
        spec_dbz_c = 1'b0;
        spec_val_c = QNAN;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_val_c = QNAN;
        end else if (a_inf) begin
            spec_val_c = {s, POS_INF[WORD_W-2:0]};
        end else if (b_inf) begin
            spec_val_c = {s, 31'd0};
        end else if (b_zero) begin
            spec_val_c = {s, POS_INF[WORD_W-2:0]};
            spec_dbz_c = 1'b1;
        end else if (a_zero) begin
            spec_val_c = {s, 31'd0};
        end else begin
            spec_c = 1'b0;
        end
    end

    // One restoring-division step.
    always_comb begin
        ge_c       = (rem >= {1'b0, mant_b});
        rem_step_c = ge_c ? (rem - {1'b0, mant_b}) : rem;
        rem_next_c = REM_W'({rem_step_c, 1'b0});
    end

    // Normalize the 26-bit quotient into mantissa/guard/sticky.
    always_comb begin
        norm_c.sign = sign_r;
        if (q[Q_W-1]) begin
            norm_c.exp    = exp_r;
            norm_c.mant   = q[25:2];
            norm_c.guard  = q[1];
            norm_c.sticky = q[0] | (rem != '0);
        end else begin
            norm_c.exp    = exp_r - 10'd1;
            norm_c.mant   = q[24:1];
            norm_c.guard  = q[0];
            norm_c.sticky = (rem != '0);
        end
    end

    fp_round_pack u_round_pack (
        .sign        (norm_r.sign),
        .exp         ($signed(norm_r.exp)),
        .mantissa    (norm_r.mant),
        .guard       (norm_r.guard),
        .sticky      (norm_r.sticky),
        .result_c    (rp_result_c),
        .overflow_c  (rp_overflow_c),
        .underflow_c (rp_underflow_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == CNT_W'(ITER - 1)) state_next = NORM;
            NORM:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rem         <= '0;
            q           <= '0;
            mant_b      <= '0;
            sign_r      <= 1'b0;
            exp_r       <= '0;
            spec_r      <= 1'b0;
            spec_dbz_r  <= 1'b0;
            spec_val_r  <= '0;
            norm_r      <= '0;
            Quotient    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rem         <= {2'b01, A[22:0]};
                        mant_b      <= {1'b1, B[22:0]};
                        q           <= '0;
                        cnt         <= '0;
                        sign_r      <= A[31] ^ B[31];
                        exp_r       <= EXP_W'($signed({2'b00, A[30:23]})
                                       - $signed({2'b00, B[30:23]})
                                       + $signed(EXP_W'(BIAS)));
                        spec_r      <= spec_c;
                        spec_dbz_r  <= spec_dbz_c;
                        spec_val_r  <= spec_val_c;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        underflow   <= 1'b0;
                    end
                end
                CALC: begin
                    q   <= {q[Q_W-2:0], ge_c};
                    rem <= rem_next_c;
                    cnt <= cnt + CNT_W'(1);
                end
                NORM: begin
                    norm_r <= norm_c;
                end
                DONE: begin
                    Quotient    <= spec_r ? spec_val_r : rp_result_c;
                    div_by_zero <= spec_r & spec_dbz_r;
                    overflow    <= ~spec_r & rp_overflow_c;
                    underflow   <= ~spec_r & rp_underflow_c;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_floating_point_divider.sv
// Self-checking bench: real-arithmetic reference model plus directed cases.
module tb_floating_point_divider;
    import fp_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] A, B;
    logic [31:0] Quotient;
    logic        busy, done, div_by_zero, overflow, underflow;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    logic [34:0] exp_q[$];
    int          t0_q[$];
    logic [31:0] hold_q   = '0;
    logic        have_hold = 1'b0;
    logic [34:0] m_e;
    int          m_t;

    floating_point_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .A           (A),
        .B           (B),
        .Quotient    (Quotient),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    endtask

    // Reference: {div_by_zero, overflow, underflow, quotient} from real arithmetic.
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [7:0]  ea, eb;
        logic [22:0] fa, fb;
        logic        s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        real         ra, rb, qr;
        logic [63:0] bits;
        int          e;
        logic [23:0] m;
        logic [24:0] m25;
        logic        g, st;
        ea = a[30:23]; fa = a[22:0];
        eb = b[30:23]; fb = b[22:0];
        s      = a[31] ^ b[31];
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        a_inf  = (ea == 8'hFF) && (fa == 0);
        b_inf  = (eb == 8'hFF) && (fb == 0);
        a_nan  = (ea == 8'hFF) && (fa != 0);
        b_nan  = (eb == 8'hFF) && (fb != 0);
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return {3'b000, 32'h7FC00000};
        if (a_inf)  return {3'b000, s, 31'h7F800000};
        if (b_inf)  return {3'b000, s, 31'h0};
        if (b_zero) return {3'b100, s, 31'h7F800000};
        if (a_zero) return {3'b000, s, 31'h0};
        ra   = real'(int'({1'b1, fa})) * (2.0 ** (real'(int'(ea)) - 150.0));
        rb   = real'(int'({1'b1, fb})) * (2.0 ** (real'(int'(eb)) - 150.0));
        qr   = ra / rb;
        bits = $realtobits(qr);
        e    = int'(bits[62:52]) - 1023 + 127;
        m    = {1'b1, bits[51:29]};
        g    = bits[28];
        st   = |bits[27:0];
        if (g && (st || m[0])) begin
            m25 = {1'b0, m} + 25'd1;
            if (m25[24]) begin
                m = m25[24:1];
                e = e + 1;
            end else begin
                m = m25[23:0];
            end
        end
        if (e >= 255) return {3'b010, s, 31'h7F800000};
        if (e <= 0)   return {3'b001, s, 31'h0};
        return {3'b000, s, 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] gen_operand();
        int          cat;
        logic [31:0] v;
        cat = int'($urandom_range(0, 11));
        v   = $urandom;
        case (cat)
            0:       v[30:23] = 8'h00;
            1:       begin v[30:23] = 8'hFF; v[22:0] = '0; end
            2:       begin v[30:23] = 8'hFF; v[22] = 1'b1; end
            3, 4:    ;
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    // Compare process: latency, results, flags, busy and hold behaviour.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", 64'(done), 64'(0));
                end else begin
                    m_e = exp_q.pop_front();
                    m_t = t0_q.pop_front();
                    check("latency", 64'(cyc - m_t), 64'(28));
                    check("quotient", 64'(Quotient), 64'(m_e[31:0]));
                    check("flags", 64'({div_by_zero, overflow, underflow}), 64'(m_e[34:32]));
                    check("busy_at_done", 64'(busy), 64'(0));
                    hold_q    = m_e[31:0];
                    have_hold = 1'b1;
                end
            end else begin
                if (exp_q.size() != 0) begin
                    check("busy", 64'(busy), 64'(1));
                    check("flags_cleared", 64'({div_by_zero, overflow, underflow}), 64'(0));
                end
                if (have_hold) check("hold", 64'(Quotient), 64'(hold_q));
            end
        end
    end

    // Issue one operation; optionally fire an ignored start at +5 clocks.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [34:0] expv, input bit busy_start);
        int k;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_q.push_back(expv);
        t0_q.push_back(cyc);
        A = $urandom; B = $urandom;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(posedge clk);
            #1;
            if (busy_start && k == 3) begin
                A = gen_operand(); B = gen_operand(); start = 1'b1;
            end else begin
                start = 1'b0;
            end
            k++;
        end
        start = 1'b0;
        if (exp_q.size() != 0) begin
            check("done_timeout", 64'(0), 64'(1));
            exp_q.delete();
            t0_q.delete();
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        int t;
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        check("rst_quotient", 64'(Quotient), 64'(0));
        check("rst_status", 64'({busy, done, div_by_zero, overflow, underflow}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Pin the reference model to hand-computed values.
        check("model_11p55_div_2p2", 64'(model(32'h4138CCCD, 32'h400CCCCD)), 64'({3'b000, 32'h40A80000}));
        check("model_6_div_m1p5",    64'(model(32'h40C00000, 32'hBFC00000)), 64'({3'b000, 32'hC0800000}));
        check("model_1_div_0",       64'(model(32'h3F800000, 32'h00000000)), 64'({3'b100, 32'h7F800000}));
        check("model_0_div_0",       64'(model(32'h00000000, 32'h00000000)), 64'({3'b000, 32'h7FC00000}));
        check("model_ovf",           64'(model(32'h7F000000, 32'h3E800000)), 64'({3'b010, 32'h7F800000}));
        check("model_1_div_3",       64'(model(32'h3F800000, 32'h40400000)), 64'({3'b000, 32'h3EAAAAAB}));

        // Directed operations with literal expectations.
        run_op(32'h4138CCCD, 32'h400CCCCD, {3'b000, 32'h40A80000}, 1'b0);
        run_op(32'h40C00000, 32'hBFC00000, {3'b000, 32'hC0800000}, 1'b1);
        run_op(32'h3F800000, 32'h00000000, {3'b100, 32'h7F800000}, 1'b0);
        run_op(32'h00000000, 32'h00000000, {3'b000, 32'h7FC00000}, 1'b0);
        run_op(32'h7F000000, 32'h3E800000, {3'b010, 32'h7F800000}, 1'b0);
        run_op(32'h00800000, 32'h4F000000, {3'b001, 32'h00000000}, 1'b0);
        run_op(32'hFF800000, 32'h3F800000, {3'b000, 32'hFF800000}, 1'b0);
        run_op(32'h3F800000, 32'hFF800000, {3'b000, 32'h80000000}, 1'b1);
        run_op(32'h80000000, 32'h40000000, {3'b000, 32'h80000000}, 1'b0);

        // Abort: busy start at +5, reset at +10, no done, Quotient cleared.
        @(negedge clk);
        A = 32'h40C00000; B = 32'h3FC00000; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t = cyc;
        while (cyc < t + 4) begin @(posedge clk); #1; end
        A = 32'h3F800000; B = 32'h40400000; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (cyc < t + 10) begin @(posedge clk); #1; end
        rst_n     = 1'b0;
        hold_q    = '0;
        have_hold = 1'b1;
        @(negedge clk);
        check("abort_quotient", 64'(Quotient), 64'(0));
        check("abort_status", 64'({busy, done, div_by_zero, overflow, underflow}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        run_op(32'h40C00000, 32'h3FC00000, {3'b000, 32'h40800000}, 1'b0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 150; i++) begin
            ra = gen_operand();
            rb = gen_operand();
            run_op(ra, rb, model(ra, rb), ($urandom_range(0, 2) == 0));
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/floating_point_divider.md
FLOATING_POINT_DIVIDER -- requirements
Module: floating_point_divider

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-002 start  input  1  one-cycle request; A and B are sampled when start=1 in IDLE.
REQ-003 A  input  32  IEEE-754 single-precision dividend.
REQ-004 B  input  32  IEEE-754 single-precision divisor.
REQ-005 Quotient  output  32  registered result, A/B.
REQ-006 busy  output  1  high from the cycle after an accepted start until done.
REQ-007 done  output  1  one-cycle pulse; Quotient and flags are valid in that cycle.
REQ-008 div_by_zero, overflow, underflow  output  1 each  status flags, valid with done.

Function
REQ-009 FSM states: IDLE, CALC, NORM, DONE; IDLE->CALC on start; CALC holds for 26 cycles; CALC->NORM->DONE->IDLE.
REQ-010 Latency SHALL be fixed: done asserts exactly 28 clocks after the start-sampling edge for all operands, including special cases.
REQ-011 start while busy SHALL be ignored, with no effect on the operation in flight.
REQ-012 Quotient and flags SHALL hold from done until the next accepted start completes.
REQ-013 Sign = A[31] XOR B[31] for all results except NaN.
REQ-014 Exponent SHALL be computed as eA - eB + 127 in a 10-bit signed register.
REQ-015 Mantissas SHALL be {1,frac}, 24 bits. Restoring division SHALL produce one quotient bit per CALC cycle, giving q = floor(mA*2^25/mB), 26 bits.
REQ-016 NORM, case q[25]=1: mantissa=q[25:2], guard=q[1], sticky=q[0]|(rem!=0).
REQ-017 NORM, case q[25]=0: mantissa=q[24:1], guard=q[0], sticky=(rem!=0), and the exponent is decremented.
REQ-018 Rounding SHALL be round-to-nearest-even. A rounding carry-out SHALL renormalize: mantissa>>1, exponent+1.
REQ-019 Final exponent >=255 SHALL give signed Inf with overflow=1.
REQ-020 Final exponent <=0 SHALL give signed zero with underflow=1; no denormal outputs.
REQ-021 Input exponent 0 SHALL be treated as zero (denormals flushed).
REQ-022 Special cases, in priority order:
- any NaN, 0/0 or Inf/Inf -> 32'h7FC00000;
- Inf/x -> signed Inf;
- x/Inf -> signed 0;
- nonzero/0 -> signed Inf with div_by_zero=1;
- 0/nonzero -> signed 0.
REQ-023 Flags SHALL be cleared when a new start is accepted.

Reset
REQ-024 rst_n low SHALL immediately force: state=IDLE; Quotient=0; busy=0; done=0; all flags=0; internal registers=0.
REQ-025 Reset mid-operation SHALL abort it with no done pulse; the next start after release SHALL operate normally.

Structure
REQ-026 Package fp_div_pkg SHALL hold: the state enum, BIAS=127, ITER=26, QNAN=32'h7FC00000, POS_INF=32'h7F800000.
REQ-027 Rounding/packing SHALL be one combinational sub-module, fp_round_pack (inputs sign, exp, mantissa, guard, sticky; outputs packed word and overflow/underflow flags). The iterative divider and FSM stay in floating_point_divider.

Verification
REQ-028 A=32'h4138CCCD (11.55), B=32'h400CCCCD (2.2), start -> done at +28 clocks; Quotient=32'h40A80000 (5.25); all flags 0.
REQ-029 A=32'h40C00000 (6.0), B=32'hBFC00000 (-1.5) -> Quotient=32'hC0800000 (-4.0).
REQ-030 A=32'h3F800000, B=0 -> Quotient=32'h7F800000, div_by_zero=1.
REQ-031 A=0, B=0 -> Quotient=32'h7FC00000.
REQ-032 A=32'h7F000000, B=32'h3E800000 -> Quotient=32'h7F800000, overflow=1.
REQ-033 Abort and busy-start case:
- start with A=32'h40C00000, B=32'h3FC00000;
- pulse start again with different operands at +5 clocks (ignored);
- drop rst_n at +10 clocks.
Required: no done pulse, Quotient=0. After release, repeating the op -> Quotient=32'h40800000 at +28 clocks.
